// File: rtl/beep_sched.sv
// Buzzer scheduler: latches key/UART/alarm requests, picks the highest-priority
// pending source and plays its fixed on/off beep pattern as a square-wave tone.
module beep_sched #(
   parameter logic [15:0] TONE_HALF = 16'd12_500,
   parameter logic [23:0] UNIT_MAX  = 24'd4_999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [2:0] req,
   input  logic       stop,
   output logic       beep,
   output logic [2:0] grant,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t      state_reg;
   logic [2:0]  pend_reg;
   logic [23:0] unit_cnt_reg;
   logic [2:0]  ph_cnt_reg;
   logic [2:0]  beep_cnt_reg;
   logic [15:0] tone_cnt_reg;
   logic        beep_reg;
   logic [2:0]  grant_reg;
   logic        busy_reg;
   logic        done_reg;

   // Pattern tables, stored as "last index" so they compare directly with counters.
   function automatic logic [2:0] on_last(input logic [2:0] g);
      case (g)
         3'b100:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] off_last(input logic [2:0] g);
      case (g)
         3'b100:  return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] beeps_last(input logic [2:0] g);
      case (g)
         3'b100:  return 3'd4;
         3'b010:  return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

   logic [2:0] top_pend;
   logic [2:0] above_grant;
   logic [2:0] ph_last;
   logic [2:0] pend_clr;
   logic       preempt;
   logic       start;
   logic       unit_tick;
   logic       phase_end;
   logic       last_beep;
   logic       tone_wrap;

   always_comb begin
      top_pend = 3'b000;
      if (pend_reg[2])
         top_pend = 3'b100;
      else if (pend_reg[1])
         top_pend = 3'b010;
      else if (pend_reg[0])
         top_pend = 3'b001;
   end

   // above_grant[i] is set when source i outranks the source now playing.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_above
         if (gi == 0) begin : g_lsb
            assign above_grant[gi] = 1'b0;
         end else begin : g_up
            assign above_grant[gi] = |grant_reg[gi-1:0];
         end
      end
   endgenerate

   always_comb begin
      ph_last = 3'd0;
      case (state_reg)
         ON:      ph_last = on_last(grant_reg);
         OFF:     ph_last = off_last(grant_reg);
         default: ph_last = 3'd0;
      endcase
   end

   assign preempt   = ((state_reg == ON) || (state_reg == OFF)) && |(pend_reg & above_grant);
   assign start     = ((state_reg == IDLE) && |pend_reg) || preempt;
   assign unit_tick = (unit_cnt_reg == UNIT_MAX);
   assign phase_end = unit_tick && (ph_cnt_reg == ph_last) && (state_reg != IDLE);
   assign last_beep = (beep_cnt_reg == beeps_last(grant_reg));
   assign tone_wrap = (tone_cnt_reg == TONE_HALF - 16'd1);
   assign pend_clr  = start ? top_pend : 3'b000;

   always_ff @(posedge sys_clk) begin
      // stop behaves like reset: everything, including pending requests, is dropped.
      if (!sys_rst_n || stop) begin
         state_reg    <= IDLE;
         pend_reg     <= 3'b000;
         unit_cnt_reg <= 24'd0;
         ph_cnt_reg   <= 3'd0;
         beep_cnt_reg <= 3'd0;
         tone_cnt_reg <= 16'd0;
         beep_reg     <= 1'b0;
         grant_reg    <= 3'b000;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         // A request arriving on the granting edge survives, so it replays later.
         pend_reg <= (pend_reg & ~pend_clr) | req;

         if (start || phase_end || (state_reg == IDLE)) begin
            unit_cnt_reg <= 24'd0;
            ph_cnt_reg   <= 3'd0;
         end else begin
            unit_cnt_reg <= unit_tick ? 24'd0 : unit_cnt_reg + 24'd1;
            if (unit_tick)
               ph_cnt_reg <= ph_cnt_reg + 3'd1;
         end

         if (start) begin
            state_reg    <= ON;
            grant_reg    <= top_pend;
            busy_reg     <= 1'b1;
            beep_reg     <= 1'b1;
            tone_cnt_reg <= 16'd0;
            beep_cnt_reg <= 3'd0;
         end else begin
            case (state_reg)
               ON: begin
                  if (phase_end) begin
                     beep_reg     <= 1'b0;
                     tone_cnt_reg <= 16'd0;
                     if (last_beep) begin
                        state_reg <= GAP;
                        done_reg  <= 1'b1;
                     end else begin
                        state_reg <= OFF;
                     end
                  end else if (tone_wrap) begin
                     tone_cnt_reg <= 16'd0;
                     beep_reg     <= ~beep_reg;
                  end else begin
                     tone_cnt_reg <= tone_cnt_reg + 16'd1;
                  end
               end
               OFF: begin
                  if (phase_end) begin
                     state_reg    <= ON;
                     beep_reg     <= 1'b1;
                     tone_cnt_reg <= 16'd0;
                     beep_cnt_reg <= beep_cnt_reg + 3'd1;
                  end
               end
               GAP: begin
                  if (phase_end) begin
                     state_reg <= IDLE;
                     grant_reg <= 3'b000;
                     busy_reg  <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign beep  = beep_reg;
   assign grant = grant_reg;
   assign busy  = busy_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with a short time unit (10 clocks) and a
// 2-clock tone half-period; cycle 0 is the first cycle after reset release.
module tb_beep_sched;

   localparam int NC = 260;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic       stop;
   logic       beep;
   logic [2:0] grant;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   beep_sched #(
      .TONE_HALF(16'd2),
      .UNIT_MAX (24'd9)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .req      (req),
      .stop     (stop),
      .beep     (beep),
      .grant    (grant),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      logic [2:0] req;
      logic       beep;
      logic [2:0] grant;
      logic       busy;
      logic       done;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   logic [2:0] stim_req  [NC];
   logic       stim_stop [NC];
   logic       beep_log  [NC];
   logic [2:0] grant_log [NC];
   logic       busy_log  [NC];
   logic       done_log  [NC];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < NC; c++) begin
         stim_req[c]  = 3'b000;
         stim_stop[c] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 3'b000;
      stop  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Logs outputs of cycle c, then drives the inputs of cycle c.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         beep_log[c]  = beep;
         grant_log[c] = grant;
         busy_log[c]  = busy;
         done_log[c]  = done;
         req          = stim_req[c];
         stop         = stim_stop[c];
         @(posedge clk);
         #1;
      end
      req  = 3'b000;
      stop = 1'b0;
   endtask

   function automatic int count_done(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (done_log[c]) n++;
      return n;
   endfunction

   function automatic int count_busy(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (busy_log[c]) n++;
      return n;
   endfunction

   function automatic int count_grant(input int lo, input int hi, input logic [2:0] g);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (grant_log[c] == g) n++;
      return n;
   endfunction

   function automatic int count_beep(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (beep_log[c]) n++;
      return n;
   endfunction

   vec_t tbl [24];

   initial begin
      // Key click: expected {beep, grant, busy, done} per cycle.
      tbl[0]  = '{3'b001, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[1]  = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[2]  = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[3]  = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[4]  = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
      tbl[5]  = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
      tbl[6]  = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[7]  = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[8]  = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
      tbl[9]  = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
      tbl[10] = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[11] = '{3'b000, 1'b1, 3'b001, 1'b1, 1'b0};
      tbl[12] = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b1};
      for (int i = 13; i <= 21; i++)
         tbl[i] = '{3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
      tbl[22] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[23] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

      // Reset state
      do_reset();
      chk("reset_outputs", int'({beep, grant, busy, done}), 0);

      // Key click, table-driven
      clear_stim();
      for (int i = 0; i < 24; i++) stim_req[i] = tbl[i].req;
      run(24);
      for (int i = 0; i < 24; i++)
         chk($sformatf("click_c%0d", i),
             int'({beep_log[i], grant_log[i], busy_log[i], done_log[i]}),
             int'({tbl[i].beep, tbl[i].grant, tbl[i].busy, tbl[i].done}));

      // UART pattern: ON 2-11, OFF 12-21, ON 22-31, GAP 32-41
      do_reset();
      clear_stim();
      stim_req[0] = 3'b010;
      run(44);
      chk("uart_grant_c2", int'(grant_log[2]), 2);
      chk("uart_beep_c2", int'(beep_log[2]), 1);
      chk("uart_beep_c11", int'(beep_log[11]), 1);
      chk("uart_off_beeps", count_beep(12, 21), 0);
      chk("uart_off_grant", count_grant(12, 21, 3'b010), 10);
      chk("uart_beep_c22", int'(beep_log[22]), 1);
      chk("uart_beep_c31", int'(beep_log[31]), 1);
      chk("uart_done_c32", int'(done_log[32]), 1);
      chk("uart_done_count", count_done(0, 43), 1);
      chk("uart_busy_c41", int'(busy_log[41]), 1);
      chk("uart_idle_c42", int'({grant_log[42], busy_log[42]}), 0);

      // Simultaneous requests: src1 first, then src0 after one IDLE cycle
      do_reset();
      clear_stim();
      stim_req[0] = 3'b011;
      run(56);
      chk("simul_grant_c2", int'(grant_log[2]), 2);
      chk("simul_grant_c41", int'(grant_log[41]), 2);
      chk("simul_idle_c42", int'({grant_log[42], busy_log[42]}), 0);
      chk("simul_grant_c43", int'(grant_log[43]), 1);
      chk("simul_beep_c43", int'(beep_log[43]), 1);
      chk("simul_done_c32", int'(done_log[32]), 1);
      chk("simul_done_c53", int'(done_log[53]), 1);
      chk("simul_done_count", count_done(0, 55), 2);

      // Preemption: click at 0, alarm at 5
      do_reset();
      clear_stim();
      stim_req[0] = 3'b001;
      stim_req[5] = 3'b100;
      run(250);
      chk("pre_grant_c6", int'(grant_log[6]), 1);
      chk("pre_grant_c7", int'(grant_log[7]), 4);
      chk("pre_beep_c7", int'(beep_log[7]), 1);
      chk("pre_off_c37", int'({beep_log[37], grant_log[37]}), 4);
      chk("pre_on_c57", int'(beep_log[57]), 1);
      chk("pre_done_c237", int'(done_log[237]), 1);
      chk("pre_done_count", count_done(0, 249), 1);
      chk("pre_busy_c246", int'(busy_log[246]), 1);
      chk("pre_idle_c247", int'(busy_log[247]), 0);
      chk("pre_no_replay", count_grant(7, 249, 3'b001), 0);

      // Repeat click during play
      do_reset();
      clear_stim();
      stim_req[0] = 3'b001;
      stim_req[4] = 3'b001;
      run(36);
      chk("rep_idle_c22", int'(busy_log[22]), 0);
      chk("rep_grant_c23", int'(grant_log[23]), 1);
      chk("rep_done_c12", int'(done_log[12]), 1);
      chk("rep_done_c33", int'(done_log[33]), 1);
      chk("rep_done_count", count_done(0, 35), 2);

      // Abort: stop beats a same-cycle click
      do_reset();
      clear_stim();
      stim_req[0]   = 3'b100;
      stim_req[50]  = 3'b001;
      stim_stop[50] = 1'b1;
      run(70);
      chk("abort_grant_c50", int'(grant_log[50]), 4);
      chk("abort_c51", int'({beep_log[51], grant_log[51], busy_log[51]}), 0);
      chk("abort_quiet", count_busy(51, 69), 0);
      chk("abort_no_done", count_done(0, 69), 0);

      // Reset asserted mid-ON
      do_reset();
      clear_stim();
      stim_req[0] = 3'b100;
      run(5);
      chk("rst_mid_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_outputs", int'({beep, grant, busy, done}), 0);
      rst_n = 1'b1;
      clear_stim();
      run(15);
      chk("rst_mid_quiet", count_busy(0, 14), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
